// File: rtl/mimo_pid_pkg.sv
// Shared constants, data type and output saturation for the MIMO PID controller.
// Optional derivative path is selected with the PID_DERIVATIVE_EN macro.
package mimo_pid_pkg;

    localparam int DW  = 14;
    localparam int PSR = 12;
    localparam int ISR = 18;
    localparam int DSR = 10;
    localparam int IW  = 32;

    localparam int DMAX = 2 ** (DW - 1) - 1;
    localparam int DMIN = -(2 ** (DW - 1));

    typedef logic signed [DW-1:0] data_t;

    localparam logic [19:0] ADDR_CFG   = 20'h00000;
    localparam logic [19:0] ADDR_PID11 = 20'h00010;
    localparam logic [19:0] ADDR_PID12 = 20'h00020;
    localparam logic [19:0] ADDR_PID21 = 20'h00030;
    localparam logic [19:0] ADDR_PID22 = 20'h00040;

    localparam logic [1:0] FLD_SET = 2'd0;
    localparam logic [1:0] FLD_KP  = 2'd1;
    localparam logic [1:0] FLD_KI  = 2'd2;
    localparam logic [1:0] FLD_KD  = 2'd3;

    function automatic data_t sat14(input logic signed [31:0] x);
        if (x > DMAX)
            return data_t'(DMAX);
        else if (x < DMIN)
            return data_t'(DMIN);
        else
            return data_t'(x[DW-1:0]);
    endfunction

endpackage

// File: rtl/mimo_pid_ctrl_if.sv
// System register bus of the MIMO PID controller.
interface mimo_pid_ctrl_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/mimo_pid_section.sv
// One PID section: error, P/I/D terms and saturated section output over three stages.
// The derivative path exists only when PID_DERIVATIVE_EN is defined.
module mimo_pid_section
    import mimo_pid_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  data_t set,
    input  data_t Kp,
    input  data_t Ki,
`ifdef PID_DERIVATIVE_EN
    input  data_t Kd,
`endif
    input  logic  int_rst,
    input  data_t in,
    output data_t sec_out
);

    localparam int EW  = DW + 1;
    localparam int PW  = 2 * DW + 1;
    localparam int SW  = IW + 1;
    localparam int DDW = PW - DSR + 1;

    function automatic logic signed [IW-1:0] sat_iw(input logic signed [SW-1:0] x);
        if (x[IW] != x[IW-1])
            return x[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        return x[IW-1:0];
    endfunction

    // c1: error and gains captured together so a gain change applies to whole samples
    logic signed [EW-1:0] err_p1;
    data_t                kp_p1;
    data_t                ki_p1;
`ifdef PID_DERIVATIVE_EN
    data_t                kd_p1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_p1 <= '0;
            kp_p1  <= '0;
            ki_p1  <= '0;
`ifdef PID_DERIVATIVE_EN
            kd_p1  <= '0;
`endif
        end else begin
            err_p1 <= EW'(set) - EW'(in);
            kp_p1  <= Kp;
            ki_p1  <= Ki;
`ifdef PID_DERIVATIVE_EN
            kd_p1  <= Kd;
`endif
        end
    end

    // c2: proportional, integral and derivative terms
    logic signed [PW-1:0]     p_prod;
    logic signed [PW-1:0]     i_prod;
    logic signed [SW-1:0]     i_sum;
    logic signed [PW-PSR-1:0] p_p2;
    logic signed [IW-1:0]     i_acc_p2;
    logic signed [DDW-1:0]    d_p2;

    assign p_prod = PW'(err_p1) * PW'(kp_p1);
    assign i_prod = PW'(err_p1) * PW'(ki_p1);
    assign i_sum  = SW'(i_acc_p2) + SW'(i_prod);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_p2     <= '0;
            i_acc_p2 <= '0;
        end else begin
            p_p2     <= (PW-PSR)'(p_prod >>> PSR);
            i_acc_p2 <= int_rst ? '0 : sat_iw(i_sum);
        end
    end

`ifdef PID_DERIVATIVE_EN
    logic signed [PW-1:0]  d_prod;
    logic signed [DDW-2:0] d_cur;
    logic signed [DDW-2:0] d_prev_p2;

    assign d_prod = PW'(err_p1) * PW'(kd_p1);
    assign d_cur  = (DDW-1)'(d_prod >>> DSR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_prev_p2 <= '0;
            d_p2      <= '0;
        end else begin
            d_prev_p2 <= d_cur;
            d_p2      <= DDW'(d_cur) - DDW'(d_prev_p2);
        end
    end
`else
    assign d_p2 = '0;
`endif

    // c3: section sum, saturated to the output range
    logic signed [31:0] sec_sum;
    assign sec_sum = 32'(p_p2) + 32'($signed(i_acc_p2[IW-1:ISR])) + 32'(d_p2);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sec_out <= '0;
        else
            sec_out <= sat14(sec_sum);
    end

endmodule

// File: rtl/mimo_pid_ctrl.sv
// Two-in/two-out PID controller: register file, bus handshake, four sections, output summers.
// Derivative path and Kd registers exist only when PID_DERIVATIVE_EN is defined.
module mimo_pid_ctrl
    import mimo_pid_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  data_t           dat_a_i,
    input  data_t           dat_b_i,
    output data_t           dat_a_o,
    output data_t           dat_b_o,
    mimo_pid_ctrl_if.slave  bus
);

    logic [3:0] cfg;
    data_t      set_r [4];
    data_t      kp_r  [4];
    data_t      ki_r  [4];
`ifdef PID_DERIVATIVE_EN
    data_t      kd_r  [4];
`endif

    logic [19:0] a;
    logic [1:0]  fld;
    logic [1:0]  sec_idx;
    logic        hit_cfg;
    logic        hit_sec;
    logic [31:0] rd_mux;
    data_t       wr_val;

    assign a      = bus.sys_addr[19:0];
    assign fld    = a[3:2];
    assign wr_val = data_t'(bus.sys_wdata[DW-1:0]);

    logic unused_bus;
    assign unused_bus = ^{bus.sys_sel, bus.sys_addr[31:20], bus.sys_wdata[31:DW]};

    always_comb begin
        hit_cfg = (a == ADDR_CFG);
        hit_sec = 1'b0;
        sec_idx = 2'd0;
        if (a[1:0] == 2'b00) begin
            case ({a[19:4], 4'h0})
                ADDR_PID11: begin hit_sec = 1'b1; sec_idx = 2'd0; end
                ADDR_PID12: begin hit_sec = 1'b1; sec_idx = 2'd1; end
                ADDR_PID21: begin hit_sec = 1'b1; sec_idx = 2'd2; end
                ADDR_PID22: begin hit_sec = 1'b1; sec_idx = 2'd3; end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        if (hit_cfg) begin
            rd_mux = {28'd0, cfg};
        end else if (hit_sec) begin
            case (fld)
                FLD_SET: rd_mux = 32'(set_r[sec_idx]);
                FLD_KP:  rd_mux = 32'(kp_r[sec_idx]);
                FLD_KI:  rd_mux = 32'(ki_r[sec_idx]);
                FLD_KD: begin
`ifdef PID_DERIVATIVE_EN
                    rd_mux = 32'(kd_r[sec_idx]);
`endif
                end
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg <= '0;
            for (int i = 0; i < 4; i++) begin
                set_r[i] <= '0;
                kp_r[i]  <= '0;
                ki_r[i]  <= '0;
`ifdef PID_DERIVATIVE_EN
                kd_r[i]  <= '0;
`endif
            end
        end else if (bus.sys_wen) begin
            if (hit_cfg) begin
                cfg <= bus.sys_wdata[3:0];
            end else if (hit_sec) begin
                case (fld)
                    FLD_SET: set_r[sec_idx] <= wr_val;
                    FLD_KP:  kp_r[sec_idx]  <= wr_val;
                    FLD_KI:  ki_r[sec_idx]  <= wr_val;
                    FLD_KD: begin
`ifdef PID_DERIVATIVE_EN
                        kd_r[sec_idx] <= wr_val;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data is captured with the strobe, so it is valid exactly in the ack cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.sys_ack   <= 1'b0;
            bus.sys_rdata <= '0;
        end else begin
            bus.sys_ack <= bus.sys_wen | bus.sys_ren;
            if (bus.sys_ren)
                bus.sys_rdata <= rd_mux;
        end
    end

    assign bus.sys_err = 1'b0;

    data_t sec_out [4];

    for (genvar s = 0; s < 4; s++) begin : g_sec
        mimo_pid_section u_sec (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .set     (set_r[s]),
            .Kp      (kp_r[s]),
            .Ki      (ki_r[s]),
`ifdef PID_DERIVATIVE_EN
            .Kd      (kd_r[s]),
`endif
            .int_rst (cfg[s]),
            .in      ((s % 2 == 0) ? dat_a_i : dat_b_i),
            .sec_out (sec_out[s])
        );
    end

    // c4: per-output sum of its two sections
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_a_o <= '0;
            dat_b_o <= '0;
        end else begin
            dat_a_o <= sat14(32'(sec_out[0]) + 32'(sec_out[1]));
            dat_b_o <= sat14(32'(sec_out[2]) + 32'(sec_out[3]));
        end
    end

endmodule

// File: tb/tb_mimo_pid_ctrl.sv
// Bench for mimo_pid_ctrl: directed scenarios plus random traffic against a sample-level model.
// Expected derivative behaviour follows the PID_DERIVATIVE_EN macro.
module tb_mimo_pid_ctrl;
    import mimo_pid_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    data_t dat_a_i, dat_b_i, dat_a_o, dat_b_o;
    data_t cur_a, cur_b;

    mimo_pid_ctrl_if bus_if ();

    mimo_pid_ctrl dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .dat_a_i (dat_a_i),
        .dat_b_i (dat_b_i),
        .dat_a_o (dat_a_o),
        .dat_b_o (dat_b_o),
        .bus     (bus_if.slave)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: register contents plus per-section integrator and previous derivative term
    longint m_par [4][4];
    int     m_cfg;
    longint m_iacc [4];
    longint m_dprev [4];
    longint exp_a_q [$];
    longint exp_b_q [$];
    longint exp_ack;
    longint exp_rd;
    bit     exp_rd_vld;

    function automatic longint sat(input longint x, input longint lo, input longint hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int m_decode(input logic [31:0] addr, output int s, output int f);
        int av;
        av = int'(addr[19:0]);
        s = 0;
        f = 0;
        if (av == 0) return 1;
        if ((av % 4) != 0 || av < 'h10 || av > 'h4C) return 0;
        s = av / 16 - 1;
        f = (av % 16) / 4;
`ifndef PID_DERIVATIVE_EN
        if (f == 3) return 0;
`endif
        return 2;
    endfunction

    function automatic longint m_read(input logic [31:0] addr);
        int s, f, k;
        logic [31:0] r;
        k = m_decode(addr, s, f);
        r = '0;
        if (k == 1) r = 32'(m_cfg & 15);
        else if (k == 2) r = 32'(m_par[s][f]);
        return longint'(r);
    endfunction

    task automatic model_step(input data_t a_in, input data_t b_in, input bit wen, input bit ren,
                              input logic [31:0] addr, input logic [31:0] wdata);
        longint p [4], d [4], iinc [4], sec [4];
        longint err, in_v, dcur;
        int s, f, k;
        exp_ack    = longint'(wen | ren);
        exp_rd_vld = ren;
        if (ren) exp_rd = m_read(addr);
        for (int i = 0; i < 4; i++) begin
            in_v     = (i % 2 == 0) ? longint'(a_in) : longint'(b_in);
            err      = m_par[i][0] - in_v;
            p[i]     = (err * m_par[i][1]) >>> PSR;
            iinc[i]  = err * m_par[i][2];
            dcur     = (err * m_par[i][3]) >>> DSR;
            d[i]     = dcur - m_dprev[i];
            m_dprev[i] = dcur;
        end
        if (wen) begin
            k = m_decode(addr, s, f);
            if (k == 1) m_cfg = int'(wdata[3:0]);
            else if (k == 2) m_par[s][f] = longint'($signed(wdata[13:0]));
        end
        for (int i = 0; i < 4; i++) begin
            if (((m_cfg >> i) & 1) != 0) m_iacc[i] = 0;
            else m_iacc[i] = sat(m_iacc[i] + iinc[i], -(64'sd1 <<< 31), (64'sd1 <<< 31) - 1);
            sec[i] = sat(p[i] + (m_iacc[i] >>> ISR) + d[i], DMIN, DMAX);
        end
        exp_a_q.push_back(sat(sec[0] + sec[1], DMIN, DMAX));
        exp_b_q.push_back(sat(sec[2] + sec[3], DMIN, DMAX));
    endtask

    task automatic cycle(input data_t a, input data_t b, input bit wen, input bit ren,
                         input logic [31:0] addr, input logic [31:0] wdata);
        dat_a_i          = a;
        dat_b_i          = b;
        bus_if.sys_wen   = wen;
        bus_if.sys_ren   = ren;
        bus_if.sys_addr  = addr;
        bus_if.sys_wdata = wdata;
        @(posedge clk);
        model_step(a, b, wen, ren, addr, wdata);
        #1;
        check_val("dat_a_o", longint'(dat_a_o), exp_a_q.pop_front());
        check_val("dat_b_o", longint'(dat_b_o), exp_b_q.pop_front());
        check_val("sys_ack", longint'(bus_if.sys_ack), exp_ack);
        check_val("sys_err", longint'(bus_if.sys_err), 0);
        if (exp_rd_vld) check_val("sys_rdata", longint'(bus_if.sys_rdata), exp_rd);
        bus_if.sys_wen = 1'b0;
        bus_if.sys_ren = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(cur_a, cur_b, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cycle(cur_a, cur_b, 1'b1, 1'b0, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        cycle(cur_a, cur_b, 1'b0, 1'b1, addr, 32'h0);
    endtask

    logic [31:0] r_addr;
    int          r;

    initial begin
        rst              = 1'b1;
        cur_a            = '0;
        cur_b            = '0;
        dat_a_i          = '0;
        dat_b_i          = '0;
        bus_if.sys_addr  = '0;
        bus_if.sys_wdata = '0;
        bus_if.sys_sel   = 4'hF;
        bus_if.sys_wen   = 1'b0;
        bus_if.sys_ren   = 1'b0;
        m_cfg            = 0;
        for (int i = 0; i < 4; i++) begin
            m_iacc[i]  = 0;
            m_dprev[i] = 0;
            for (int j = 0; j < 4; j++) m_par[i][j] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dat_a_o", longint'(dat_a_o), 0);
        check_val("rst_dat_b_o", longint'(dat_b_o), 0);
        check_val("rst_ack", longint'(bus_if.sys_ack), 0);
        check_val("rst_rdata", longint'(bus_if.sys_rdata), 0);
        rst = 1'b0;
        repeat (3) begin
            exp_a_q.push_back(0);
            exp_b_q.push_back(0);
        end

        rd(32'h00);
        check_val("rd_cfg_reset", longint'(bus_if.sys_rdata), 0);
        rd(32'h14);
        check_val("rd_kp11_reset", longint'(bus_if.sys_rdata), 0);
        idle(1);

        wr(32'h14, 32'(-3000));
        rd(32'h14);
        check_val("rd_kp11_neg", longint'(bus_if.sys_rdata), longint'(32'hFFFFF448));
        wr(32'h7C, 32'h1234);
        rd(32'h7C);
        check_val("rd_unmapped", longint'(bus_if.sys_rdata), 0);
        rd(32'h14);
        check_val("rd_kp11_kept", longint'(bus_if.sys_rdata), longint'(32'hFFFFF448));

        wr(32'h10, 32'd1000);
        wr(32'h14, 32'd4096);
        cur_a = '0;
        idle(6);
        check_val("p_only_a", longint'(dat_a_o), 1000);
        check_val("p_only_b", longint'(dat_b_o), 0);

        wr(32'h10, 32'd7000);
        wr(32'h14, 32'd8191);
        cur_a = data_t'(-8000);
        idle(6);
        check_val("p_sat_hi", longint'(dat_a_o), 8191);
        wr(32'h10, 32'(-7000));
        cur_a = data_t'(8000);
        idle(6);
        check_val("p_sat_lo", longint'(dat_a_o), -8192);

        wr(32'h14, 32'd0);
        wr(32'h10, 32'd7000);
        wr(32'h18, 32'd1000);
        cur_a = '0;
        idle(400);
        check_val("int_sat", longint'(dat_a_o), 8191);
        wr(32'h00, 32'h1);
        idle(4);
        check_val("int_clear", longint'(dat_a_o), 0);
        wr(32'h00, 32'hE);
        idle(20);
        check_val("int_resume", longint'(dat_a_o > 0), 1);

        wr(32'h18, 32'd0);
        wr(32'h00, 32'h1);
        wr(32'h00, 32'h0);
        wr(32'h10, 32'd0);
        wr(32'h1C, 32'd1024);
        idle(6);
        cur_a = data_t'(-500);
        idle(3);
        check_val("d_before", longint'(dat_a_o), 0);
        idle(1);
`ifdef PID_DERIVATIVE_EN
        check_val("d_pulse", longint'(dat_a_o), 500);
`else
        check_val("d_pulse", longint'(dat_a_o), 0);
`endif
        idle(1);
        check_val("d_after", longint'(dat_a_o), 0);

        cycle(cur_a, cur_b, 1'b1, 1'b1, 32'h20, 32'd123);
        idle(1);
        check_val("wr_rd_single_ack", longint'(bus_if.sys_ack), 0);

        for (int n = 0; n < 800; n++) begin
            cur_a = data_t'($urandom);
            cur_b = data_t'($urandom);
            r = int'($urandom_range(0, 20));
            if (r == 0) r_addr = 32'h0;
            else if (r <= 16) r_addr = 32'h10 + 32'((r - 1) / 4) * 32'h10 + 32'((r - 1) % 4) * 32'h4;
            else if (r == 17) r_addr = 32'h7C;
            else if (r == 18) r_addr = 32'h12;
            else if (r == 19) r_addr = 32'h00100010;
            else r_addr = 32'h00080010;
            case ($urandom_range(0, 3))
                0: cycle(cur_a, cur_b, 1'b1, 1'b0, r_addr, $urandom);
                1: cycle(cur_a, cur_b, 1'b0, 1'b1, r_addr, 32'h0);
                default: idle(1);
            endcase
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mimo_pid_ctrl.md
Name: mimo_pid_ctrl

Overview:
- Two-input, two-output MIMO PID controller for the 125 MHz, 14-bit ADC/DAC datapath.
- It contains four independent PID sections, PIDxy, where x is the output and y is the input: PID11 (a→a), PID12 (b→a), PID21 (a→b), PID22 (b→b).
- Each output is the saturated sum of its two sections.
- Set points, gains and integrator resets are configured over the system register bus.

Parameters:
- DW, 14: input/output data width, two's complement.
- PSR, 12: right shift applied to the proportional product.
- ISR, 18: right shift applied to the integrator value.
- DSR, 10: right shift applied to the derivative product.
- IW, 32: integrator accumulator width.

Ports:
- clk_i  in  1  clock, 125 MHz.
- rst_i  in  1  synchronous, active-high reset.
- dat_a_i  in  14  input a, signed.
- dat_b_i  in  14  input b, signed.
- dat_a_o  out  14  output a, signed.
- dat_b_o  out  14  output b, signed.
- sys_addr  in  32  bus address; only [19:0] is decoded.
- sys_wdata  in  32  write data.
- sys_sel  in  4  byte select; ignored, all writes are full-word.
- sys_wen  in  1  write strobe, one cycle.
- sys_ren  in  1  read strobe, one cycle.
- sys_rdata  out  32  read data.
- sys_err  out  1  always 0.
- sys_ack  out  1  access acknowledge.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Register map (offsets):
  - 0x00 CFG[3:0]: integrator reset for PID22, PID21, PID12, PID11 (bit3..bit0). Level-sensitive: while a bit is 1, that section's integrator is held at 0.
  - 0x10/14/18/1C: PID11 set point, Kp, Ki, Kd.
  - 0x20–0x2C: PID12, same layout.
  - 0x30–0x3C: PID21, same layout.
  - 0x40–0x4C: PID22, same layout.
  - All fields are 14-bit signed, taken from wdata[13:0].
  - Reads return the field sign-extended to 32 bits. CFG reads zero-extended.
  - Unmapped addresses read 0 and ignore writes.
- Bus handshake:
  - Writes update the register on the clock edge where sys_wen=1.
  - sys_ack = registered (sys_wen|sys_ren), i.e. asserted exactly one cycle after the strobe.
  - sys_rdata is registered and valid in the ack cycle.
  - A simultaneous wen and ren produces a single ack.
- Reset: all registers, integrators, pipeline registers, dat_*_o, sys_ack and sys_rdata are 0.
- Per section, cycle-level:
  - c1: err = set − in, computed at 15 bits signed and registered.
  - c2, proportional: P = (err·Kp)[28:PSR], arithmetic, registered.
  - c2, integral: I_acc ← sat_IW(I_acc + err·Ki), saturating at ±2^31 with no wrap. If the CFG bit is set, I_acc ← 0 instead.
  - c2, derivative: D_cur = (err·Kd)[28:DSR]; D_prev ← D_cur; D = D_cur − D_prev.
  - c3: sec_out = sat14(P + I_acc[IW−1:ISR] + D), range −8192..8191.
- Output: dat_a_o = sat14(PID11 + PID12) and dat_b_o = sat14(PID21 + PID22), registered at c4.
- Latency from input to output is 4 cycles.
- Gain or set-point changes take effect on the next c1.
- All arithmetic is signed; intermediate widths are sized to be overflow-free before each saturation.

Optional Feature:
- PID_DERIVATIVE_EN:
  - Defined: the D path exists as described above.
  - Undefined: D is forced to 0, Kd registers read 0 and ignore writes, and the derivative logic is not synthesized.

Decomposition:
- Package mimo_pid_pkg holds:
  - register offsets,
  - DW/PSR/ISR/DSR/IW constants,
  - a 14-bit signed data typedef,
  - a sat14 function.
- Sub-module mimo_pid_section: one PID section with inputs set, Kp, Ki, Kd, int_rst and in, and output sec_out. It is instantiated four times.
- The top level contains the register file, bus logic and output summers.

Test Plan:
- Reset, then read 0x00 and 0x14 → rdata 0, ack one cycle after ren, dat_a_o = dat_b_o = 0.
- Write Kp11 = −3000, then read 0x14 → rdata 0xFFFFF448. Write to 0x7C → reads 0, no side effects.
- Set11 = 1000, Kp11 = 4096, Ki = Kd = 0, dat_a_i = 0 → dat_a_o = 1000 exactly 4 cycles after the input settles, and dat_b_o = 0.
- Set11 = 7000, Kp11 = 8191, dat_a_i = −8000 → dat_a_o saturates at 8191. With set11 = −7000 and dat_a_i = 8000 → dat_a_o = −8192.
- Integrator:
  - Set11 = 7000, Ki11 = 1000, Kp = Kd = 0, in = 0 → I_acc grows by 7,000,000 per cycle, so dat_a_o ramps by about 26.7 LSB/cycle until it saturates at 8191.
  - Write CFG = 0b0001 → dat_a_o returns to 0 within 4 cycles.
  - Write CFG = 0b1110 → the ramp resumes.
- Derivative (with PID_DERIVATIVE_EN):
  - Kd11 = 1024, set = 0, dat_a_i steps 0 → −500 → dat_a_o shows a one-cycle pulse of 500, then returns to 0.
  - Without the macro → dat_a_o stays 0.
